// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// ---------------
// Program sequencer for the cpu control FSM. It holds the program counter,
// fetches 16-bit instructions over a request/valid handshake, presents each
// instruction on a stable register and issues a one-cycle run pulse. It then
// waits for done, resolves branches (format 2'b10) and advances the PC.
//
// Optional feature: define FETCH_SEQUENCER_STEP_EN to add the step input and
// the STEP_WAIT state. In that build the sequencer pauses after every
// instruction until step is high. Without the macro, execution is continuous.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-low reset
//   start      level; (re)starts execution at PC 0 from IDLE or HALT
//   mem_req    one-cycle fetch request
//   mem_addr   fetch address (equals pc)
//   mem_valid  instruction read data valid
//   mem_rdata  instruction word
//   d_inst     registered instruction presented to the cpu
//   run        one-cycle start pulse to the cpu
//   done       cpu instruction-complete pulse
//   cmp_eq/gt/lt  datapath compare flags, sampled in the done cycle
//   step       (FETCH_SEQUENCER_STEP_EN only) advance out of STEP_WAIT
//   pc         current program counter
//   busy       high in every state except IDLE and HALT
//   halted     high in HALT
//   err        sticky memory-timeout flag
module fetch_sequencer #(
  parameter int PC_W        = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_valid,
  input  logic [15:0]     mem_rdata,
  output logic [15:0]     d_inst,
  output logic            run,
  input  logic            done,
  input  logic            cmp_eq,
  input  logic            cmp_gt,
  input  logic            cmp_lt,
`ifdef FETCH_SEQUENCER_STEP_EN
  input  logic            step,
`endif
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            err
);

`ifdef FETCH_SEQUENCER_STEP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_MEM, S_DECODE, S_WAIT_DONE, S_HALT, S_STEP_WAIT
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_MEM, S_DECODE, S_WAIT_DONE, S_HALT
  } state_t;
`endif

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [15:0]     inst_reg, inst_next;
  logic            err_reg, err_next;
  logic [7:0]      cnt_reg, cnt_next;

  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] pc_inc;
  logic            cond_hit;
  logic            taken;

  // Branch target is d_inst[PC_W+3:4]; bits beyond the 16-bit word read as 0.
  for (genvar gi = 0; gi < PC_W; gi++) begin : g_target
    if (gi + 4 < 16) begin : g_in
      assign branch_target[gi] = inst_reg[gi+4];
    end else begin : g_ext
      assign branch_target[gi] = 1'b0;
    end
  end

  assign pc_inc = pc_reg + {{(PC_W-1){1'b0}}, 1'b1};

  always_comb begin
    cond_hit = 1'b0;
    case (inst_reg[3:2])
      2'b00:   cond_hit = cmp_eq;
      2'b01:   cond_hit = cmp_gt;
      2'b10:   cond_hit = cmp_lt;
      default: cond_hit = 1'b0;
    endcase
  end

  assign taken = (inst_reg[1:0] == 2'b10) && cond_hit;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      inst_reg  <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    mem_req    = 1'b0;
    run        = 1'b0;
    busy       = 1'b1;
    halted     = 1'b0;

    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = S_FETCH;
          pc_next    = '0;
          err_next   = 1'b0;
        end
      end

      S_FETCH: begin
        mem_req    = 1'b1;
        cnt_next   = '0;
        state_next = S_WAIT_MEM;
      end

      S_WAIT_MEM: begin
        // Valid data takes priority over an expiring timeout in the same cycle.
        if (mem_valid) begin
          inst_next  = mem_rdata;
          state_next = S_DECODE;
        end else if (cnt_reg == TMO_LAST) begin
          err_next   = 1'b1;
          state_next = S_HALT;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      S_DECODE: begin
        if (inst_reg[1:0] == 2'b11) begin
          state_next = S_HALT;
        end else begin
          run        = 1'b1;
          state_next = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (done) begin
          pc_next = taken ? branch_target : pc_inc;
`ifdef FETCH_SEQUENCER_STEP_EN
          // A step arriving together with done is not consumed here.
          state_next = S_STEP_WAIT;
`else
          state_next = S_FETCH;
`endif
        end
      end

`ifdef FETCH_SEQUENCER_STEP_EN
      S_STEP_WAIT: begin
        if (step) begin
          state_next = S_FETCH;
        end
      end
`endif

      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
        if (start) begin
          state_next = S_FETCH;
          pc_next    = '0;
          err_next   = 1'b0;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign mem_addr = pc_reg;
  assign pc       = pc_reg;
  assign d_inst   = inst_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer.
// Directed programs run against a bench memory and cpu responder. An
// instruction-level reference tracks the expected PC. One negedge process
// checks every fetch address, run pulse and d_inst stability. Literal
// expectations pin the key addresses and flags.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic        cmp_eq;
  logic        cmp_gt;
  logic        cmp_lt;
  logic        step;
  logic        mem_valid = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        done = 1'b0;
  logic        mem_req;
  logic        run;
  logic        busy;
  logic        halted;
  logic        err;
  logic [7:0]  mem_addr;
  logic [7:0]  pc;
  logic [15:0] d_inst;

  fetch_sequencer #(.PC_W(8), .MEM_TIMEOUT(15)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_valid(mem_valid),
    .mem_rdata(mem_rdata),
    .d_inst(d_inst),
    .run(run),
    .done(done),
    .cmp_eq(cmp_eq),
    .cmp_gt(cmp_gt),
    .cmp_lt(cmp_lt),
`ifdef FETCH_SEQUENCER_STEP_EN
    .step(step),
`endif
    .pc(pc),
    .busy(busy),
    .halted(halted),
    .err(err)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] imem [256];
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [7:0]  mem_pend_addr = 8'h00;
  bit          cpu_en = 1'b1;
  int          done_cnt = 0;
  logic [7:0]  exp_pc = 8'h00;
  logic [7:0]  fetch_addr = 8'h00;
  logic [15:0] cur_inst = 16'h0000;
  bit          in_exec = 1'b0;
  bit          run_prev = 1'b0;
  int          run_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Reference PC after an instruction completes, from the instruction rules.
  function automatic logic [7:0] model_next(input logic [15:0] inst, input logic [7:0] cur,
                                            input logic eq, input logic gt, input logic lt);
    logic t;
    t = 1'b0;
    if (inst[1:0] == 2'b10) begin
      case (inst[3:2])
        2'b00:   t = eq;
        2'b01:   t = gt;
        2'b10:   t = lt;
        default: t = 1'b0;
      endcase
    end
    return t ? inst[11:4] : cur + 8'd1;
  endfunction

  // Compare process plus memory and cpu responders, all on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      exp_pc   = 8'h00;
      in_exec  = 1'b0;
      done_cnt = 0;
      mem_cnt  = 0;
      mem_valid = 1'b0;
      done     = 1'b0;
      run_prev = 1'b0;
    end else begin
      if (start && !busy) exp_pc = 8'h00;
      if (mem_req) begin
        check("fetch_addr", mem_addr, exp_pc);
        check("pc_out", pc, exp_pc);
        fetch_addr = mem_addr;
      end
      if (run) begin
        check("run_single", run_prev, 0);
        check("d_inst_at_run", d_inst, imem[fetch_addr]);
        cur_inst = imem[fetch_addr];
        in_exec  = 1'b1;
        run_cnt++;
      end else if (in_exec) begin
        check("d_inst_stable", d_inst, cur_inst);
      end
      run_prev = run;

      mem_valid = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          mem_valid = 1'b1;
          mem_rdata = imem[mem_pend_addr];
        end
      end
      if (mem_req && mem_lat > 0) begin
        mem_cnt       = mem_lat;
        mem_pend_addr = mem_addr;
      end

      done = 1'b0;
      if (run && cpu_en) begin
        done_cnt = 2;
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) begin
          done    = 1'b1;
          in_exec = 1'b0;
          exp_pc  = model_next(cur_inst, exp_pc, cmp_eq, cmp_gt, cmp_lt);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_fetch(input string name, input logic [7:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!mem_req && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!mem_req) begin
      total++;
      bad++;
      $display("FAIL %s: no mem_req within 60 cycles, expected addr %0h", name, exp);
    end else begin
      check(name, mem_addr, exp);
    end
  endtask

  task automatic wait_run(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!run && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!run) begin
      total++;
      bad++;
      $display("FAIL %s: no run pulse within 60 cycles, expected 1", name);
    end
  endtask

  task automatic wait_halt(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!halted && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, halted, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    reset = 1'b0;
    start = 1'b0;
    cmp_eq = 1'b0;
    cmp_gt = 1'b0;
    cmp_lt = 1'b0;
    step = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;

    // Reset state
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_err", err, 0);
    check("rst_pc", pc, 0);
    check("rst_run", run, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_d_inst", d_inst, 0);

    // A: plain instruction, then a taken branch to a halt instruction
    imem[0] = 16'h2401;
    imem[1] = 16'h0A02;
    imem[8'hA0] = 16'h0003;
    cmp_eq = 1'b1;
    pulse_start();
    wait_fetch("a_fetch0", 8'h00);
    wait_run("a_run");
    check("a_d_inst", d_inst, 16'h2401);
    @(negedge clk);
    check("a_run_low", run, 0);
    wait_fetch("a_next_addr", 8'h01);
    wait_fetch("a_branch_taken", 8'hA0);
    rc = run_cnt;
    wait_halt("a_halt");
    check("a_halt_pc", pc, 8'hA0);
    check("a_halt_no_run", run_cnt, rc);
    check("a_halt_inst", d_inst, 16'h0003);
    check("a_halt_busy", busy, 0);

    // B: untaken branch, taken branch to FF, wrap, ignored start, reset mid-execute
    cmp_eq = 1'b0;
    cmp_gt = 1'b1;
    imem[2] = 16'h0FF6;
    imem[8'hFF] = 16'h1235;
    pulse_start();
    wait_fetch("b_fetch0", 8'h00);
    wait_fetch("b_fetch1", 8'h01);
    pulse_start();
    wait_fetch("b_not_taken", 8'h02);
    wait_fetch("b_branch_ff", 8'hFF);
    wait_fetch("b_wrap", 8'h00);
    cpu_en = 1'b0;
    wait_run("b_run");
    tick();
    tick();
    check("b_busy_wait_done", busy, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("b_rst_busy", busy, 0);
    check("b_rst_pc", pc, 0);
    check("b_rst_run", run, 0);
    check("b_rst_d_inst", d_inst, 0);
    check("b_rst_halted", halted, 0);
    cpu_en = 1'b1;

    // C: memory never answers, timeout after 15 WAIT_MEM cycles, then restart
    imem[1] = 16'h0003;
    mem_lat = 0;
    pulse_start();
    wait_fetch("c_fetch0", 8'h00);
    repeat (15) @(posedge clk);
    #1;
    check("c_pre_timeout_halted", halted, 0);
    check("c_pre_timeout_busy", busy, 1);
    @(posedge clk);
    #1;
    check("c_timeout_halted", halted, 1);
    check("c_timeout_err", err, 1);
    mem_lat = 1;
    pulse_start();
    wait_fetch("c_restart_addr", 8'h00);
    check("c_err_cleared", err, 0);
    wait_halt("c_halt");
    check("c_halt_pc", pc, 8'h01);
    check("c_halt_inst", d_inst, 16'h0003);

    // D: valid arrives on the last allowed WAIT_MEM cycle and wins
    mem_lat = 15;
    pulse_start();
    wait_fetch("d_fetch0", 8'h00);
    wait_run("d_run");
    check("d_inst_late", d_inst, 16'h2401);
    check("d_err_after_late", err, 0);
    wait_fetch("d_fetch1", 8'h01);
    wait_halt("d_halt");
    check("d_err_final", err, 0);
    check("d_halt_pc", pc, 8'h01);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
